// File: rtl/imm_extend_pipe.sv
// Immediate extender (sign / zero / upper / branch) feeding a 2-entry elastic
// buffer with valid/ready handshakes on both sides.
module imm_extend_pipe #(
  parameter int unsigned IN_W     = 16,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;

  logic [1:0]       count_q, count_d;
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [OUT_W-1:0] data_q [2];
  logic [OUT_W-1:0] data_d [2];
  logic [1:0]       mode_q [2];
  logic [1:0]       mode_d [2];

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] ext_data;
  logic             push;
  logic             pop;

  // in_ready depends only on registered count and reset, never on out_ready
  assign in_ready  = (count_q != 2'd2) & ~reset;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? data_q[rptr_q] : '0;
  assign out_mode  = out_valid ? mode_q[rptr_q] : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    sext     = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    ext_data = sext;
    case (mode_e'(in_mode))
      MODE_SIGN:   ext_data = sext;
      MODE_ZERO:   ext_data = {{EXT_W{1'b0}}, in_imm};
      MODE_UPPER:  ext_data = {in_imm, {EXT_W{1'b0}}};
      MODE_BRANCH: ext_data = sext << BR_SHIFT;
      default:     ext_data = sext;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    mode_d  = mode_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      data_d[wptr_q] = ext_data;
      mode_d[wptr_q] = in_mode;
      wptr_d         = ~wptr_q;
    end
    if (pop) begin
      rptr_d = ~rptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      data_q  <= '{default: '0};
      mode_q  <= '{default: '0};
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: default 16->32 instance plus an 8->16 instance.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset;

  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode, out_mode;
  logic [31:0] out_data;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  in_imm8;
  logic [1:0]  in_mode8, out_mode8;
  logic [15:0] out_data8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_extend_pipe dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
  );

  imm_extend_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(2)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_imm(in_imm8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_mode(out_mode8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one entry into the wide instance, capture the head, then pop it.
  task automatic push_pop(input logic [1:0] m, input logic [15:0] imm,
                          output logic [31:0] d, output logic [1:0] mo);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = m;
    in_imm    = imm;
    step();
    in_valid  = 1'b0;
    d         = out_data;
    mo        = out_mode;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic push_pop8(input logic [1:0] m, input logic [7:0] imm,
                           output logic [15:0] d);
    out_ready8 = 1'b0;
    in_valid8  = 1'b1;
    in_mode8   = m;
    in_imm8    = imm;
    step();
    in_valid8  = 1'b0;
    d          = out_data8;
    out_ready8 = 1'b1;
    step();
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (out_mode !== 2'b00) begin bad++; $display("FAIL reset_out_mode got=%b exp=00", out_mode); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    reset = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    step();
  endtask

  task automatic test_sign();
    logic [31:0] d;
    logic [1:0]  mo;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_imm    = 16'h0001;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sign_pre_valid got=%0b exp=0", out_valid); end
    step();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sign_post_valid got=%0b exp=1", out_valid); end
    total++; if (out_data !== 32'h0000_0001) begin bad++; $display("FAIL sign_0001 got=%h exp=00000001", out_data); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sign_drained got=%0b exp=0", out_valid); end
    push_pop(2'b00, 16'h8001, d, mo);
    total++; if (d !== 32'hFFFF_8001) begin bad++; $display("FAIL sign_8001 got=%h exp=ffff8001", d); end
  endtask

  task automatic test_modes();
    logic [31:0] d;
    logic [1:0]  mo;
    push_pop(2'b01, 16'hFFFF, d, mo);
    total++; if (d !== 32'h0000_FFFF) begin bad++; $display("FAIL zero_ffff got=%h exp=0000ffff", d); end
    total++; if (mo !== 2'b01) begin bad++; $display("FAIL zero_mode got=%b exp=01", mo); end
    push_pop(2'b10, 16'h1234, d, mo);
    total++; if (d !== 32'h1234_0000) begin bad++; $display("FAIL upper_1234 got=%h exp=12340000", d); end
    total++; if (mo !== 2'b10) begin bad++; $display("FAIL upper_mode got=%b exp=10", mo); end
    push_pop(2'b11, 16'hFFFF, d, mo);
    total++; if (d !== 32'hFFFF_FFFC) begin bad++; $display("FAIL branch_ffff got=%h exp=fffffffc", d); end
    total++; if (mo !== 2'b11) begin bad++; $display("FAIL branch_mode got=%b exp=11", mo); end
    push_pop(2'b11, 16'h0004, d, mo);
    total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL branch_0004 got=%h exp=00000010", d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic [31:0] exp_seq [3];
    logic        pushed;
    exp_seq[0] = 32'h0000_0001;
    exp_seq[1] = 32'hFFFF_8000;
    exp_seq[2] = 32'h0000_7FFF;
    out_ready = 1'b0;
    in_mode   = 2'b00;
    in_valid  = 1'b1;
    in_imm    = 16'h0001;
    step();
    in_imm    = 16'h8000;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_b got=%0b exp=1", in_ready); end
    step();
    in_imm    = 16'h7FFF;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%0b exp=0", in_ready); end
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_held got=%0b exp=0", in_ready); end
    total++; if (out_data !== 32'h0000_0001) begin bad++; $display("FAIL bp_stable got=%h exp=00000001", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pushed = in_valid & in_ready;
      if (out_valid) got.push_back(out_data);
      step();
      if (pushed) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== exp_seq[i]) begin bad++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got[i], exp_seq[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    out_ready = 1'b1;
    in_mode   = 2'b00;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        in_imm   = 16'(i);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i > 0) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%0b exp=1", i, out_valid); end
      end
      if (i < 8) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%0b exp=1", i, in_ready); end
      end
      if (out_valid) got.push_back(out_data);
      step();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_empty got=%0b exp=0", out_valid); end
    total++; if (got.size() != 8) begin bad++; $display("FAIL stream_count got=%0d exp=8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== 32'(i)) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, got[i], 32'(i)); end
      end
    end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b01;
    in_imm    = 16'hAAAA;
    step();
    in_imm    = 16'h5555;
    step();
    in_valid  = 1'b0;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rf_full got=%0b exp=0", in_ready); end
    reset = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_valid got=%0b exp=0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rf_data got=%h exp=0", out_data); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rf_in_ready got=%0b exp=0", in_ready); end
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rf_ready_after got=%0b exp=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rf_stale[%0d] got=%0b exp=0", i, out_valid); end
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_narrow();
    logic [15:0] d;
    push_pop8(2'b00, 8'h80, d);
    total++; if (d !== 16'hFF80) begin bad++; $display("FAIL n_sign_80 got=%h exp=ff80", d); end
    push_pop8(2'b01, 8'h80, d);
    total++; if (d !== 16'h0080) begin bad++; $display("FAIL n_zero_80 got=%h exp=0080", d); end
    push_pop8(2'b10, 8'hAB, d);
    total++; if (d !== 16'hAB00) begin bad++; $display("FAIL n_upper_ab got=%h exp=ab00", d); end
    push_pop8(2'b11, 8'hFF, d);
    total++; if (d !== 16'hFFFC) begin bad++; $display("FAIL n_branch_ff got=%h exp=fffc", d); end
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0; out_ready  = 1'b0; in_imm  = '0; in_mode  = '0;
    in_valid8  = 1'b0; out_ready8 = 1'b0; in_imm8 = '0; in_mode8 = '0;
    test_reset();
    test_sign();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_reset_full();
    test_narrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
